// File: rtl/ram_access_arbiter.sv
// Round-robin scheduler that shares one RAM/DMA port between three requesters
// (0 = file loader, 1 = decompress handler, 2 = CNN engine). One access at a
// time: a single read or write strobe is issued, completion is awaited under a
// timeout, and a one-cycle done pulse returns to the winner. All outputs are
// registered.
module ram_access_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            grant,
  output logic [2:0]            done,
  output logic                  err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_rd,
  output logic                  ram_wr,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          win_q, win_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          grant_q, grant_d;
  logic [2:0]          done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ram_rd_q, ram_rd_d;
  logic                ram_wr_q, ram_wr_d;
  logic [1:0]          pick_s;

  // Round-robin search: start just after the previous winner and wrap mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    idx   = last;
    pick  = 2'd0;
    found = 1'b0;
    for (int s = 0; s < 3; s++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(req, last_q);

  // Next-state and next-output logic; strobes and done default to a single cycle.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    done_d      = 3'b000;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 3'b000) begin
          // Latch winner and its operands; the strobe is visible during ISSUE.
          win_d       = pick_s;
          we_d        = we[pick_s];
          ram_addr_d  = addr[int'(pick_s) * ADDR_W +: ADDR_W];
          ram_wdata_d = wdata[int'(pick_s) * DATA_W +: DATA_W];
          grant_d     = 3'b001 << pick_s;
          ram_rd_d    = ~we[pick_s];
          ram_wr_d    = we[pick_s];
          busy_d      = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          grant_d = 3'b000;
          busy_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion has priority over a timeout landing in the same cycle.
        if (ram_done) begin
          if (!we_q) begin
            rdata_d = ram_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          done_d  = grant_q;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d  = grant_q;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        last_d  = win_q;
        grant_d = 3'b000;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 3'b000;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any access.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      last_q      <= 2'd2;
      win_q       <= 2'd0;
      we_q        <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      grant_q     <= 3'b000;
      done_q      <= 3'b000;
      err_q       <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_wdata_q <= {DATA_W{1'b0}};
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_rd    = ram_rd_q;
  assign ram_wr    = ram_wr_q;

endmodule
